// File: rtl/mul4s_arb_pkg.sv
// Shared types and helpers for the mul4s_rr_arbiter block: operand/product
// widths, the output-slot state enum and the round-robin pick function.
package mul4s_arb_pkg;

  localparam int OPW    = 4;
  localparam int PW     = 8;
  localparam int MAXREQ = 8;
  localparam int MAXIDW = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic              found;
    logic [MAXIDW-1:0] idx;
  } pick_t;

  // First asserted request at or above ptr, wrapping at nreq.
  function automatic pick_t rr_pick(input logic [MAXREQ-1:0] req,
                                    input logic [MAXIDW-1:0] ptr,
                                    input int                nreq);
    pick_t r;
    int    idx;
    r = '0;
    for (int i = 0; i < MAXREQ; i++) begin
      idx = (int'(ptr) + i) % nreq;
      if ((i < nreq) && !r.found && req[idx]) begin
        r.found = 1'b1;
        r.idx   = MAXIDW'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mul4s_rr_arbiter_if.sv
// Requester and response channel bundle for mul4s_rr_arbiter.
// master: requesters plus downstream consumer; slave: the arbiter.
interface mul4s_rr_arbiter_if
  import mul4s_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [OPW*NREQ-1:0] req_a;
  logic [OPW*NREQ-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic signed [PW-1:0] rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/mul4s_bw.sv
// Combinational 4x4 signed Baugh-Wooley array multiplier. Partial products
// that mix one sign bit with one magnitude bit are complemented; the
// correction constant (2^4 plus an inverted MSB, i.e. 2^7) seeds the
// accumulator, and each row is added by a ripple of full-adder cells.
module mul4s_bw
  import mul4s_arb_pkg::*;
(
  input  logic signed [OPW-1:0] i_a,
  input  logic signed [OPW-1:0] i_b,
  output logic signed [PW-1:0]  o_p
);

  function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  // Accumulate the four partial-product rows onto the correction constant.
  always_comb begin : bw_array
    logic [PW-1:0] w_row;
    logic [PW-1:0] w_acc;
    logic [1:0]    w_cs;
    logic          w_c;
    w_acc = PW'(1 << OPW) | PW'(1 << (PW - 1));
    for (int i = 0; i < OPW; i++) begin
      w_row = '0;
      for (int j = 0; j < OPW; j++) begin
        if ((i == OPW - 1) != (j == OPW - 1))
          w_row[i+j] = ~(i_a[j] & i_b[i]);
        else
          w_row[i+j] = i_a[j] & i_b[i];
      end
      w_c = 1'b0;
      for (int k = 0; k < PW; k++) begin
        w_cs     = fa_cell(w_acc[k], w_row[k], w_c);
        w_acc[k] = w_cs[0];
        w_c      = w_cs[1];
      end
    end
    o_p = w_acc;
  end

endmodule

// File: rtl/mul4s_rr_arbiter.sv
// Round-robin arbiter sharing one 4x4 signed multiplier among NREQ
// requesters, with a registered, id-tagged product slot.
// Optional macro MUL4S_ARB_PIPE_EN inserts an operand stage ahead of the
// multiplier (latency 2, throughput unchanged).
module mul4s_rr_arbiter
  import mul4s_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic               clk,
  input logic               rst,
  mul4s_rr_arbiter_if.slave bus
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [MAXIDW-1:0]     r_ptr;
  logic [MAXREQ-1:0]     w_req8;
  pick_t                 w_pick;
  logic                  w_free;
  logic                  w_grant;
  logic                  w_load;
  logic [IDW-1:0]        w_gid;
  logic signed [OPW-1:0] w_ga;
  logic signed [OPW-1:0] w_gb;
  logic signed [OPW-1:0] w_ma;
  logic signed [OPW-1:0] w_mb;
  logic [IDW-1:0]        w_lid;
  logic signed [PW-1:0]  w_p;
  logic signed [PW-1:0]  r_p;
  logic [IDW-1:0]        r_id;

  // Slot can take a new product if empty or draining this cycle.
  assign w_free = (r_state == EMPTY) | bus.rsp_ready;

  // Widen the request vector to the package's fixed search width.
  always_comb begin
    w_req8 = '0;
    for (int i = 0; i < NREQ; i++) w_req8[i] = bus.req_valid[i];
  end

  assign w_pick = rr_pick(w_req8, r_ptr, NREQ);
  assign w_gid  = w_pick.idx[IDW-1:0];
  assign w_ga   = bus.req_a[OPW*w_gid +: OPW];
  assign w_gb   = bus.req_b[OPW*w_gid +: OPW];

`ifdef MUL4S_ARB_PIPE_EN
  logic signed [OPW-1:0] r_a_p0;
  logic signed [OPW-1:0] r_b_p0;
  logic [IDW-1:0]        r_id_p0;
  logic                  r_vld_p0;

  // Operand stage moves into the slot whenever the slot is free.
  assign w_grant = ~rst & w_pick.found & (~r_vld_p0 | w_free);
  assign w_load  = r_vld_p0 & w_free;
  assign w_ma    = r_a_p0;
  assign w_mb    = r_b_p0;
  assign w_lid   = r_id_p0;

  // Stage p0: granted operands wait here for the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_a_p0   <= '0;
      r_b_p0   <= '0;
      r_id_p0  <= '0;
    end else if (w_grant) begin
      r_vld_p0 <= 1'b1;
      r_a_p0   <= w_ga;
      r_b_p0   <= w_gb;
      r_id_p0  <= w_gid;
    end else if (w_free) begin
      r_vld_p0 <= 1'b0;
    end
  end
`else
  assign w_grant = ~rst & w_pick.found & w_free;
  assign w_load  = w_grant;
  assign w_ma    = w_ga;
  assign w_mb    = w_gb;
  assign w_lid   = w_gid;
`endif

  // One-hot accept to the granted requester only.
  always_comb begin
    bus.req_ready = '0;
    if (w_grant) bus.req_ready[w_gid] = 1'b1;
  end

  mul4s_bw u_mul (
    .i_a (w_ma),
    .i_b (w_mb),
    .o_p (w_p)
  );

  // Pointer moves just past the last granted requester.
  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (w_grant)
      r_ptr <= (w_pick.idx == MAXIDW'(NREQ - 1)) ? '0 : w_pick.idx + 1'b1;
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Slot next state: fill on load, empty on drain without refill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_load) w_state_nxt = FULL;
      FULL:    if (bus.rsp_ready && !w_load) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Product slot: capture product and owner tag on load, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p  <= '0;
      r_id <= '0;
    end else if (w_load) begin
      r_p  <= w_p;
      r_id <= w_lid;
    end
  end

  assign bus.rsp_valid = (r_state == FULL);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_p     = r_p;

endmodule

// File: tb/tb_mul4s_rr_arbiter.sv
// Directed bench for mul4s_rr_arbiter (default single-stage build).
module tb_mul4s_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [3:0] ca [5];
  logic [3:0] cb [5];
  logic [7:0] cp [5];
  logic [7:0] q_p [$];
  logic [1:0] q_id [$];
  int         n_rsp = 0;

  mul4s_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mul4s_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[4*i +: 4] = a;
    bus.req_b[4*i +: 4] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of the exhaustive run: score drains, record accepts, advance.
  task automatic obs_cycle(output bit acc);
    logic signed [3:0] sa;
    logic signed [3:0] sb;
    int                pr;
    acc = 1'b0;
    #1;
    if (bus.rsp_valid && bus.rsp_ready) begin
      checks++;
      assert (q_p.size() != 0) else begin
        errors++;
        $error("FAIL ex_extra observed=response id %0d expected=no response", bus.rsp_id);
      end
      if (q_p.size() != 0) begin
        chk("ex_p", 8'(bus.rsp_p), q_p.pop_front());
        chk("ex_id", 8'(bus.rsp_id), 8'(q_id.pop_front()));
        n_rsp++;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        sa = bus.req_a[4*i +: 4];
        sb = bus.req_b[4*i +: 4];
        pr = int'(sa) * int'(sb);
        q_p.push_back(8'(pr));
        q_id.push_back(2'(i));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit         got;
    int         budget;
    int         rq;
    logic [3:0] ea;
    logic [3:0] eb;

    ca = '{4'h8, 4'h7, 4'hF, 4'h0, 4'h3};
    cb = '{4'h8, 4'h8, 4'hF, 4'hB, 4'hE};
    cp = '{8'h40, 8'hC8, 8'h01, 8'h00, 8'hFA};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 8'(bus.rsp_valid), 8'h00);
    chk("rst_id", 8'(bus.rsp_id), 8'h00);
    chk("rst_p", 8'(bus.rsp_p), 8'h00);
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_ready", 8'(bus.req_ready), 8'h00);
    bus.req_valid = '0;
    rst           = 1'b0;

    // Signed corner products on requester 0, one-cycle latency
    for (int k = 0; k < 5; k++) begin
      set_op(0, ca[k], cb[k]);
      bus.req_valid = 4'b0001;
      #1;
      chk("corner_ready", 8'(bus.req_ready), 8'h01);
      tick();
      bus.req_valid = '0;
      chk("corner_valid", 8'(bus.rsp_valid), 8'h01);
      chk("corner_p", 8'(bus.rsp_p), cp[k]);
      chk("corner_id", 8'(bus.rsp_id), 8'h00);
    end
    tick();
    chk("drain_valid", 8'(bus.rsp_valid), 8'h00);
    chk("drain_hold_p", 8'(bus.rsp_p), 8'hFA);

    // All four valid from ptr=0: grants 0,1,2,3,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, 4'h1, 4'h2);
    set_op(1, 4'h2, 4'h2);
    set_op(2, 4'h3, 4'h2);
    set_op(3, 4'h4, 4'h2);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 8'(bus.req_ready), 8'(1 << (k % 4)));
      tick();
      chk("rr_valid", 8'(bus.rsp_valid), 8'h01);
      chk("rr_id", 8'(bus.rsp_id), 8'(k % 4));
      chk("rr_p", 8'(bus.rsp_p), 8'(2 * ((k % 4) + 1)));
    end

    // Requesters 1 and 3 with ptr=2: 3 first, then 1
    bus.req_valid = 4'b1010;
    #1;
    chk("wrap_ready3", 8'(bus.req_ready), 8'h08);
    tick();
    chk("wrap_id3", 8'(bus.rsp_id), 8'h03);
    chk("wrap_p3", 8'(bus.rsp_p), 8'h08);
    #1;
    chk("wrap_ready1", 8'(bus.req_ready), 8'h02);
    tick();
    chk("wrap_id1", 8'(bus.rsp_id), 8'h01);
    chk("wrap_p1", 8'(bus.rsp_p), 8'h04);

    // Stall with 0xC8 held, then drain and refill in one cycle
    set_op(0, 4'h7, 4'h8);
    bus.req_valid = 4'b0001;
    #1;
    chk("stall_ready0", 8'(bus.req_ready), 8'h01);
    tick();
    chk("stall_p0", 8'(bus.rsp_p), 8'hC8);
    set_op(2, 4'h2, 4'h3);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 8'(bus.req_ready), 8'h00);
      tick();
      chk("stall_valid", 8'(bus.rsp_valid), 8'h01);
      chk("stall_p", 8'(bus.rsp_p), 8'hC8);
      chk("stall_id", 8'(bus.rsp_id), 8'h00);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("release_ready", 8'(bus.req_ready), 8'h04);
    tick();
    chk("release_valid", 8'(bus.rsp_valid), 8'h01);
    chk("release_p", 8'(bus.rsp_p), 8'h06);
    chk("release_id", 8'(bus.rsp_id), 8'h02);

    // Reset mid-operation with a held product and pending requests
    set_op(1, 4'hD, 4'h5);
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;
    #1;
    chk("mrst_ready_a", 8'(bus.req_ready), 8'h00);
    tick();
    chk("mrst_valid", 8'(bus.rsp_valid), 8'h00);
    chk("mrst_p", 8'(bus.rsp_p), 8'h00);
    chk("mrst_id", 8'(bus.rsp_id), 8'h00);
    #1;
    chk("mrst_ready_b", 8'(bus.req_ready), 8'h00);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 8'(bus.req_ready), 8'h02);
    tick();
    chk("post_rst_valid", 8'(bus.rsp_valid), 8'h01);
    chk("post_rst_p", 8'(bus.rsp_p), 8'hF1);
    chk("post_rst_id", 8'(bus.rsp_id), 8'h01);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("post_rst_drain", 8'(bus.rsp_valid), 8'h00);

    // All 256 operand pairs on random requesters with random backpressure
    for (int n = 0; n < 256; n++) begin
      ea = n[7:4];
      eb = n[3:0];
      rq = int'($urandom_range(0, NREQ - 1));
      set_op(rq, ea, eb);
      bus.req_valid = 4'(1 << rq);
      got    = 1'b0;
      budget = 0;
      while (!got && budget < 64) begin
        bus.rsp_ready = 1'($urandom_range(0, 1));
        obs_cycle(got);
        budget++;
      end
      checks++;
      assert (got) else begin
        errors++;
        $error("FAIL ex_accept observed=no grant after %0d cycles expected=grant for pair %0d", budget, n);
      end
      bus.req_valid = '0;
    end
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) obs_cycle(got);
    checks++;
    assert (n_rsp == 256) else begin
      errors++;
      $error("FAIL ex_count observed=%0d expected=256", n_rsp);
    end
    checks++;
    assert (q_p.size() == 0) else begin
      errors++;
      $error("FAIL ex_left observed=%0d expected=0", q_p.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
